// File: rtl/clk_gate_ctrl_fg.sv
// Fine-grained clock-gate enable controller for one gated partition.
// It gates after a run of idle, drained cycles, wakes on demand, delays ready by WAKE_CYCLES, and counts gated cycles.
module clk_gate_ctrl_fg #(
  parameter int IDLE_CYCLES = 8,
  parameter int WAKE_CYCLES = 2,
  parameter int CNT_WIDTH   = 4,
  parameter int STAT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable_i,
  input  logic                  force_on_i,
  input  logic                  activity_i,
  input  logic                  drained_i,
  output logic                  clkEn_o,
  output logic                  ready_o,
  output logic                  gated_o,
  output logic [STAT_WIDTH-1:0] gatedCycles_o
);

  localparam logic [1:0] ST_ON   = 2'd0;
  localparam logic [1:0] ST_OFF  = 2'd1;
  localparam logic [1:0] ST_WAKE = 2'd2;

  localparam logic [CNT_WIDTH-1:0]  CNT_ONE   = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0]  IDLE_LAST = CNT_WIDTH'(IDLE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0]  WAKE_LAST = CNT_WIDTH'((WAKE_CYCLES > 0) ? (WAKE_CYCLES - 1) : 0);
  localparam logic [STAT_WIDTH-1:0] STAT_ONE  = STAT_WIDTH'(1);
  localparam logic [STAT_WIDTH-1:0] STAT_MAX  = {STAT_WIDTH{1'b1}};
  // With no wake latency the partition goes straight back to ON.
  localparam logic [1:0]            WAKE_DEST = (WAKE_CYCLES == 0) ? ST_ON : ST_WAKE;

  logic [1:0]            state_q, state_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [STAT_WIDTH-1:0] stat_q, stat_d;
  logic                  clk_en_q, clk_en_d;
  logic                  ready_q, ready_d;
  logic                  gated_q, gated_d;
  logic                  qual_s;
  logic                  wake_s;

  // Idle-qualify and wake conditions.
  always_comb begin
    qual_s = enable_i & ~force_on_i & ~activity_i & drained_i;
    wake_s = activity_i | force_on_i | ~enable_i;
  end

  // Next-state and idle/wake counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_ON: begin
        if (qual_s && (cnt_q == IDLE_LAST)) begin
          state_d = ST_OFF;
          cnt_d   = '0;
        end else if (qual_s) begin
          cnt_d = cnt_q + CNT_ONE;
        end else begin
          cnt_d = '0;
        end
      end
      ST_OFF: begin
        cnt_d = '0;
        if (wake_s) begin
          state_d = WAKE_DEST;
        end else begin
          state_d = ST_OFF;
        end
      end
      ST_WAKE: begin
        if (cnt_q == WAKE_LAST) begin
          state_d = ST_ON;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ST_ON;
        cnt_d   = '0;
      end
    endcase
  end

  // Saturating gated-cycle statistic: counts every cycle spent in OFF.
  always_comb begin
    if ((state_q == ST_OFF) && (stat_q != STAT_MAX)) begin
      stat_d = stat_q + STAT_ONE;
    end else begin
      stat_d = stat_q;
    end
  end

  // Outputs are decoded from the next state so the flops track the state register.
  always_comb begin
    clk_en_d = (state_d != ST_OFF);
    ready_d  = (state_d == ST_ON);
    gated_d  = (state_d == ST_OFF);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_ON;
      cnt_q    <= '0;
      stat_q   <= '0;
      clk_en_q <= 1'b1;
      ready_q  <= 1'b1;
      gated_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      stat_q   <= stat_d;
      clk_en_q <= clk_en_d;
      ready_q  <= ready_d;
      gated_q  <= gated_d;
    end
  end

  assign clkEn_o       = clk_en_q;
  assign ready_o       = ready_q;
  assign gated_o       = gated_q;
  assign gatedCycles_o = stat_q;

endmodule

// File: tb/tb_clk_gate_ctrl_fg.sv
// Directed, table-driven bench for clk_gate_ctrl_fg (defaults), plus a
// STAT_WIDTH=4 / WAKE_CYCLES=0 instance for saturation and zero-latency wake.
module tb_clk_gate_ctrl_fg;

  logic        clk = 1'b0;
  logic        reset, enable_i, force_on_i, activity_i, drained_i;
  logic        clk_en_a, ready_a, gated_a;
  logic [31:0] stat_a;
  logic        clk_en_b, ready_b, gated_b;
  logic [3:0]  stat_b;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  clk_gate_ctrl_fg #(.IDLE_CYCLES(8), .WAKE_CYCLES(2), .CNT_WIDTH(4), .STAT_WIDTH(32)) dut_a (
    .clk(clk), .reset(reset), .enable_i(enable_i), .force_on_i(force_on_i),
    .activity_i(activity_i), .drained_i(drained_i),
    .clkEn_o(clk_en_a), .ready_o(ready_a), .gated_o(gated_a), .gatedCycles_o(stat_a));

  clk_gate_ctrl_fg #(.IDLE_CYCLES(8), .WAKE_CYCLES(0), .CNT_WIDTH(4), .STAT_WIDTH(4)) dut_b (
    .clk(clk), .reset(reset), .enable_i(enable_i), .force_on_i(force_on_i),
    .activity_i(activity_i), .drained_i(drained_i),
    .clkEn_o(clk_en_b), .ready_o(ready_b), .gated_o(gated_b), .gatedCycles_o(stat_b));

  typedef struct {
    logic        rst, en, frc, act, drn;
    logic        e_clk, e_rdy, e_gat;
    logic [31:0] e_stat;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic rst, en, frc, act, drn,
                              input logic e_clk, e_rdy, e_gat, input int e_stat);
    vec_t v;
    v.rst = rst; v.en = en; v.frc = frc; v.act = act; v.drn = drn;
    v.e_clk = e_clk; v.e_rdy = e_rdy; v.e_gat = e_gat; v.e_stat = 32'(e_stat);
    vecs.push_back(v);
  endfunction

  // Qualifying idle cycle with the expected outputs after it.
  function automatic void add_q(input logic e_clk, e_rdy, e_gat, input int e_stat);
    add(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, e_clk, e_rdy, e_gat, e_stat);
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s step %0d: got %0d expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic rst, en, frc, act, drn);
    @(negedge clk);
    reset = rst; enable_i = en; force_on_i = frc; activity_i = act; drained_i = drn;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; enable_i = 1'b0; force_on_i = 1'b0; activity_i = 1'b0; drained_i = 1'b0;

    // Reset state
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0);
    // Eight qualifying cycles gate on the eighth; statistics then climb.
    for (int i = 0; i < 7; i++) add_q(1'b1, 1'b1, 1'b0, 0);
    add_q(1'b0, 1'b0, 1'b1, 0);
    add_q(1'b0, 1'b0, 1'b1, 1);
    add_q(1'b0, 1'b0, 1'b1, 2);
    add_q(1'b0, 1'b0, 1'b1, 3);
    // Activity pulse: WAKE for two cycles, statistic frozen afterwards.
    add(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4);
    add_q(1'b1, 1'b0, 1'b0, 4);
    add_q(1'b1, 1'b1, 1'b0, 4);
    // Seven idle then activity on the eighth restarts the window.
    for (int i = 0; i < 7; i++) add_q(1'b1, 1'b1, 1'b0, 4);
    add(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4);
    for (int i = 0; i < 7; i++) add_q(1'b1, 1'b1, 1'b0, 4);
    add_q(1'b0, 1'b0, 1'b1, 4);
    // force_on while OFF wakes exactly like activity.
    add(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5);
    add(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5);
    add(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 5);
    // Not drained, forced on, or not drained with activity: never gates.
    for (int i = 0; i < 20; i++) add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5);
    for (int i = 0; i < 20; i++) add(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 5);
    for (int i = 0; i < 5; i++)  add(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 5);
    // enable_i low in ON restarts the idle count.
    for (int i = 0; i < 7; i++) add_q(1'b1, 1'b1, 1'b0, 5);
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 5);
    for (int i = 0; i < 7; i++) add_q(1'b1, 1'b1, 1'b0, 5);
    add_q(1'b0, 1'b0, 1'b1, 5);
    // enable_i low in OFF wakes; reset in WAKE returns to ON.
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 6);
    add(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 0);
    // Gate again, then reset in OFF.
    for (int i = 0; i < 7; i++) add_q(1'b1, 1'b1, 1'b0, 0);
    add_q(1'b0, 1'b0, 1'b1, 0);
    add_q(1'b0, 1'b0, 1'b1, 1);
    add_q(1'b0, 1'b0, 1'b1, 2);
    add(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].en, vecs[i].frc, vecs[i].act, vecs[i].drn);
      chk("clkEn", i, 32'(clk_en_a), 32'(vecs[i].e_clk));
      chk("ready", i, 32'(ready_a),  32'(vecs[i].e_rdy));
      chk("gated", i, 32'(gated_a),  32'(vecs[i].e_gat));
      chk("gatedCycles", i, stat_a, vecs[i].e_stat);
    end

    // Saturation and zero-latency wake on the narrow instance.
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("b_gated_entry", 0, 32'(gated_b), 32'd1);
    chk("b_clkEn_entry", 0, 32'(clk_en_b), 32'd0);
    for (int i = 1; i <= 20; i++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      chk("b_stat_sat", i, 32'(stat_b), (i < 15) ? 32'(i) : 32'd15);
    end
    chk("a_stat_20", 0, stat_a, 32'd20);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    chk("b_clkEn_wake0", 0, 32'(clk_en_b), 32'd1);
    chk("b_ready_wake0", 0, 32'(ready_b),  32'd1);
    chk("b_gated_wake0", 0, 32'(gated_b),  32'd0);
    chk("b_stat_hold",   0, 32'(stat_b),   32'd15);
    chk("a_ready_wake2", 0, 32'(ready_a),  32'd0);
    chk("a_stat_21",     0, stat_a,        32'd21);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    chk("b_stat_hold2",  1, 32'(stat_b),   32'd15);
    chk("b_ready_on",    1, 32'(ready_b),  32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
